serial_paralelo_aligner: RTL
============================

Name: serial_paralelo_aligner

Overview:
- Receive-side counterpart of the 2-bit paralelo-to-serial transmitter.
- Deserializes the 2-bit lane (serial) at clk16f into 9-bit parallel words {valid, data[7:0]}.
- Acquires byte alignment by hunting for the COM idle symbol, which the transmitter sends when it has no valid data.
- Sits after the transmitter in the 2b serial datapath; its output is compared against the original paralelo bus.

Parameters:
COM_BYTE, 8'hBC, idle/alignment symbol sent by transmitter when valid=0
LOCK_COUNT, 4, consecutive aligned COM bytes required to declare lock (range 2..15)
LOSS_COUNT, 2, consecutive misaligned COM detections that drop lock (used only with SP_LOCK_LOSS_EN; range 1..7)

Ports:
clk16f  input  1  single clock; one 2-bit pair sampled per rising edge
reset_L  input  1  asynchronous, active-low reset
serial  input  2  serial lane; serial[1] is the more significant bit of each pair
paralelo  output  9  {valid, data[7:0]}, registered
active  output  1  1 while in ALIGNED state, registered

Behaviour:
- Reset (reset_L=0, asynchronous): paralelo=9'h000, active=0, state=SEARCH, shift reg=0, phase=0, counters=0. Reset asserted mid-byte discards the partial byte.
- Bit order: MSB pair first. A byte occupies 4 consecutive edges carrying bits [7:6], [5:4], [3:2], [1:0].
- Shift register sr[5:0]. Combinational window w = {sr[5:0], serial} on every edge; sr <= w[5:0].
- phase: 2-bit counter, wraps 3->0. The edge with phase==3 is the byte boundary; w is the complete byte.
- SEARCH:
  - Any edge with w==COM_BYTE: phase<=0, com_cnt<=1, go to VERIFY.
  - Otherwise phase is don't-care.
  - paralelo=0, active=0.
- VERIFY, at boundary edges only:
  - w==COM_BYTE: com_cnt++. When com_cnt+1==LOCK_COUNT, go to ALIGNED and set active<=1 on the same edge.
  - w!=COM_BYTE: com_cnt<=0, go to SEARCH.
  - paralelo stays 0.
- ALIGNED, at each boundary edge:
  - w==COM_BYTE: paralelo<={1'b0, 8'h00}.
  - Otherwise: paralelo<={1'b1, w}.
  - paralelo holds for the 4 edges until the next boundary.
- Latency: paralelo updates on the same edge that samples the byte's last pair, i.e. 3 edges after its first pair.
- Data byte equal to COM_BYTE cannot be transmitted as valid. This is a protocol rule; it is not flagged.
- Without SP_LOCK_LOSS_EN, lock is left only through reset.

Optional Feature:
- Macro: SP_LOCK_LOSS_EN.
- Defined:
  - In ALIGNED, a non-boundary edge with w==COM_BYTE increments mis_cnt (3-bit, saturating).
  - A boundary COM clears mis_cnt.
  - When mis_cnt reaches LOSS_COUNT, go to SEARCH on that edge: active<=0, paralelo<=0, mis_cnt<=0.
  - A boundary COM and a non-boundary COM cannot coincide (one edge), so no priority rule is needed.
- Undefined: mis_cnt logic absent; ALIGNED is terminal until reset_L=0.

Test Plan:
- Reset: hold reset_L=0 while driving random serial -> paralelo=0, active=0. Release, drive 3 COM bytes (2'b10,2'b11,2'b11,2'b00 each) -> active still 0, paralelo=0.
- Lock: 1 random pair then 4 COM bytes, then byte 8'h5A -> active rises at the boundary edge of the 4th COM. paralelo=9'h15A exactly 4 edges later, held 4 edges.
- Idle after lock: COM between data 8'h01, 8'hFF -> paralelo sequence 9'h101, 9'h000, 9'h1FF, one word per 4 clk16f edges.
- Broken verify: 2 COMs then 8'h00 -> returns to SEARCH, active stays 0. Next 4 COMs -> lock achieved.
- Reset mid-byte: in ALIGNED, assert reset_L after 2 pairs of byte 8'hA5 -> paralelo=0 and active=0 immediately (asynchronous); relock requires 4 COMs.
- SP_LOCK_LOSS_EN: after lock, shift stream by one pair so COM lands at phase 1 twice -> active=0 on 2nd detection. Without the macro, same stimulus -> active stays 1 and paralelo shows garbage valid words.

Source files
------------

// File: rtl/serial_paralelo_aligner_if.sv
// Lane and word bus between the 2-bit serial receiver and its consumer.
// master drives the serial lane; slave is the aligner.
interface serial_paralelo_aligner_if;
   logic [1:0] serial;
   logic [8:0] paralelo;
   logic       active;

   modport master (output serial, input paralelo, input active);
   modport slave  (input serial, output paralelo, output active);
endinterface

// File: rtl/serial_paralelo_aligner.sv
// 2-bit serial to 9-bit {valid, data} deserializer that aligns on COM idle symbols.
// Optional macro SP_LOCK_LOSS_EN: drop lock after repeated misaligned COM detections.
module serial_paralelo_aligner #(
   parameter logic [7:0]  COM_BYTE   = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned LOSS_COUNT = 2
) (
   input logic                     clk16f,
   input logic                     reset_L,
   serial_paralelo_aligner_if.slave bus
);

   if (LOCK_COUNT < 2 || LOCK_COUNT > 15 || LOSS_COUNT < 1 || LOSS_COUNT > 7) begin : g_bad_cfg
      $error("serial_paralelo_aligner: LOCK_COUNT or LOSS_COUNT out of range");
   end

   localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

   typedef enum logic [1:0] {StSearch, StVerify, StAligned} state_e;

   state_e     state;
   logic [5:0] sr;
   logic [1:0] phase;
   logic [3:0] com_cnt;
   logic [8:0] par;
   logic       act;
   logic [7:0] w;
   logic       is_com;
   logic       boundary;

`ifdef SP_LOCK_LOSS_EN
   localparam logic [2:0] LossCnt = 3'(LOSS_COUNT);
   logic [2:0] mis_cnt;
   logic [2:0] mis_inc;
   assign mis_inc = (mis_cnt == 3'd7) ? 3'd7 : mis_cnt + 3'd1;
`endif

   assign w        = {sr, bus.serial};
   assign is_com   = (w == COM_BYTE);
   assign boundary = (phase == 2'd3);

   always_ff @(posedge clk16f or negedge reset_L) begin
      if (!reset_L) begin
         state   <= StSearch;
         sr      <= 6'd0;
         phase   <= 2'd0;
         com_cnt <= 4'd0;
         par     <= 9'h000;
         act     <= 1'b0;
`ifdef SP_LOCK_LOSS_EN
         mis_cnt <= 3'd0;
`endif
      end else begin
         sr    <= w[5:0];
         phase <= phase + 2'd1;
         unique case (state)
            StSearch: begin
               // Byte boundary is anchored on the edge that completes a COM.
               if (is_com) begin
                  phase   <= 2'd0;
                  com_cnt <= 4'd1;
                  state   <= StVerify;
               end
            end
            StVerify: begin
               if (boundary) begin
                  if (is_com) begin
                     com_cnt <= com_cnt + 4'd1;
                     if (com_cnt + 4'd1 == LockCnt) begin
                        state <= StAligned;
                        act   <= 1'b1;
                     end
                  end else begin
                     com_cnt <= 4'd0;
                     state   <= StSearch;
                  end
               end
            end
            StAligned: begin
               if (boundary) begin
                  par <= is_com ? 9'h000 : {1'b1, w};
               end
`ifdef SP_LOCK_LOSS_EN
               if (boundary && is_com) begin
                  mis_cnt <= 3'd0;
               end else if (!boundary && is_com) begin
                  if (mis_inc == LossCnt) begin
                     state   <= StSearch;
                     act     <= 1'b0;
                     par     <= 9'h000;
                     mis_cnt <= 3'd0;
                     com_cnt <= 4'd0;
                  end else begin
                     mis_cnt <= mis_inc;
                  end
               end
`endif
            end
            default: state <= StSearch;
         endcase
      end
   end

   assign bus.paralelo = par;
   assign bus.active   = act;

endmodule
